ripple_carry_adder: RTL and testbench

- Parameterizable unsigned/two's-complement ripple-carry adder: sum = a + b + cin.
- Combinational carry chain built from cascaded 1-bit full-adder cells.
- Sum, carry-out, signed-overflow and valid are registered once; one result per clock.
- Generic datapath arithmetic leaf, used where a small, area-minimal adder is acceptable.

---
 rtl/ripple_carry_adder_pkg.sv | 4 +
 rtl/ripple_carry_adder_full_adder.sv | 14 +
 rtl/ripple_carry_adder.sv | 50 +++++
 tb/tb_ripple_carry_adder.sv | 137 +++++++++++++
 4 files changed

// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants for the ripple-carry adder slice.
package ripple_carry_adder_pkg;
    localparam int DEFAULT_WIDTH = 4;
endpackage

// File: rtl/ripple_carry_adder_full_adder.sv
// One-bit full-adder cell; the top cascades WIDTH of these into a carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/ripple_carry_adder.sv
// Ripple-carry adder (sum = a + b + cin) with a single output register stage.
module ripple_carry_adder
    import ripple_carry_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             out_valid
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    // Strict LSB-to-MSB ripple: each cell's carry-out feeds the next cell.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum       <= '0;
            cout      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_valid) begin
            sum       <= s;
            cout      <= c[WIDTH];
            // Signed overflow: carry into the MSB differs from carry out of it.
            overflow  <= c[WIDTH] ^ c[WIDTH-1];
            out_valid <= 1'b1;
        end else begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench: directed, exhaustive and random stimulus against an arithmetic model.
module tb_ripple_carry_adder;
    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;
    localparam int HALF = 1 << (W - 1);

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         out_valid;

    int n_tests = 0;
    int n_fail  = 0;

    // model of the registered outputs
    int m_sum = 0;
    int m_cout = 0;
    int m_ov = 0;
    int m_vld = 0;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= HALF) ? v - (1 << W) : v;
    endfunction

    // Drive one cycle, advance the model, compare all outputs just after the edge.
    task automatic step(input int r, input int v, input int av, input int bv, input int cv);
        int total, ssum;
        rst = r[0]; in_valid = v[0]; a = av[W-1:0]; b = bv[W-1:0]; cin = cv[0];
        @(posedge clk);
        #1;
        if (r != 0) begin
            m_sum = 0; m_cout = 0; m_ov = 0; m_vld = 0;
        end else if (v != 0) begin
            total  = av + bv + cv;
            ssum   = to_signed(av) + to_signed(bv) + cv;
            m_sum  = total & MASK;
            m_cout = (total > MASK) ? 1 : 0;
            m_ov   = (ssum >= HALF || ssum < -HALF) ? 1 : 0;
            m_vld  = 1;
        end else begin
            m_vld = 0;
        end
        check("sum", int'(sum), m_sum);
        check("cout", int'(cout), m_cout);
        check("overflow", int'(overflow), m_ov);
        check("out_valid", int'(out_valid), m_vld);
    endtask

    typedef struct {
        int a, b, c, s, co, ov;
    } vec_t;

    vec_t dir[6] = '{
        '{1, 1, 0, 2, 0, 0},
        '{6, 5, 0, 11, 0, 1},
        '{12, 11, 1, 8, 1, 0},
        '{15, 15, 0, 14, 1, 0},
        '{15, 15, 1, 15, 1, 0},
        '{9, 6, 1, 0, 1, 0}
    };

    initial begin
        int hold_sum, hold_cout;

        // reset with arbitrary inputs
        step(1, 1, 9, 7, 1);
        step(1, 1, 3, 12, 0);
        step(0, 1, 0, 0, 0);

        // spec examples, also checked against literal values
        foreach (dir[k]) begin
            step(0, 1, dir[k].a, dir[k].b, dir[k].c);
            check("dir_sum", int'(sum), dir[k].s);
            check("dir_cout", int'(cout), dir[k].co);
            check("dir_ov", int'(overflow), dir[k].ov);
        end

        // back-to-back then idle: valid drops, data holds
        step(0, 1, 3, 4, 0);
        step(0, 1, 7, 1, 0);
        step(0, 1, 13, 5, 1);
        hold_sum = int'(sum); hold_cout = int'(cout);
        step(0, 0, 2, 2, 0);
        check("hold_sum", int'(sum), 3);
        check("hold_cout", int'(cout), 1);
        step(0, 0, 8, 8, 1);
        check("hold_sum2", int'(sum), hold_sum);
        check("hold_cout2", int'(cout), hold_cout);

        // reset mid-stream
        step(0, 1, 15, 1, 0);
        step(1, 1, 6, 6, 1);
        check("rst_mid_vld", int'(out_valid), 0);
        step(0, 1, 2, 3, 0);

        // exhaustive, back-to-back
        for (int i = 0; i < (1 << (2 * W + 1)); i++)
            step(0, 1, (i >> (W + 1)) & MASK, (i >> 1) & MASK, i & 1);

        // random with gaps and occasional reset
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 19) == 0) ? 1 : 0, ($urandom_range(0, 3) != 0) ? 1 : 0,
                 $urandom_range(0, MASK), $urandom_range(0, MASK), $urandom_range(0, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
